// File: rtl/rdma_meta_arbiter_ctrl.sv
// rtl/rdma_meta_arbiter_ctrl.sv - round-robin RDMA metadata arbiter with transfer watchdog
//
// Purpose: collects per-channel start requests, validates their lengths, grants
// one channel at a time by round-robin, hands its metadata to the encapsulator
// over a valid/ready handshake and then tracks the packet on a monitor tap until
// tlast (or watchdog expiry).
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   ch_enable/ch_start             per-channel enable and start level (rising edge acts)
//   ch_len/ch_dst_ip/ch_dst_port   packed per-channel request fields
//   clr_stat                       synchronous clear of counters and sticky flags
//   o_meta_*, o_meta_valid         metadata to encapsulator
//   i_meta_ready                   encapsulator accepts metadata
//   mon_tvalid/tready/tlast        monitor tap on packet output stream
//   ch_pending, ch_err_len/ovf     per-channel status (errors sticky)
//   o_timeout, o_busy, o_state     watchdog flag (sticky), activity, FSM state
//   ch_pkt_cnt                     packed 32-bit completed-packet counters
module rdma_meta_arbiter_ctrl #(
  parameter int          N_CH        = 4,
  parameter int          LEN_W       = 16,
  parameter int          MAX_LEN     = 1472,
  parameter int          TIMEOUT_CYC = 65535,
  parameter logic [31:0] SRC_IP      = 32'hAC1F09CA,
  parameter logic [15:0] SRC_PORT    = 16'hCE06,
  localparam int         CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       ch_enable,
  input  logic [N_CH-1:0]       ch_start,
  input  logic [N_CH*LEN_W-1:0] ch_len,
  input  logic [N_CH*32-1:0]    ch_dst_ip,
  input  logic [N_CH*16-1:0]    ch_dst_port,
  input  logic                  clr_stat,
  output logic [LEN_W-1:0]      o_meta_len,
  output logic [31:0]           o_meta_src_ip,
  output logic [31:0]           o_meta_dst_ip,
  output logic [15:0]           o_meta_src_port,
  output logic [15:0]           o_meta_dst_port,
  output logic [CH_W-1:0]       o_meta_ch,
  output logic                  o_meta_valid,
  input  logic                  i_meta_ready,
  input  logic                  mon_tvalid,
  input  logic                  mon_tready,
  input  logic                  mon_tlast,
  output logic [N_CH-1:0]       ch_pending,
  output logic [N_CH-1:0]       ch_err_len,
  output logic [N_CH-1:0]       ch_err_ovf,
  output logic                  o_timeout,
  output logic                  o_busy,
  output logic [1:0]            o_state,
  output logic [N_CH*32-1:0]    ch_pkt_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_META = 2'd1,
    S_XFER = 2'd2
  } state_t;

  // One extra bit so a MAX_LEN at the top of the LEN_W range still compares correctly
  localparam logic [LEN_W:0] MAX_LEN_L = (LEN_W+1)'(MAX_LEN);
  localparam logic [15:0]    WD_LAST   = 16'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [N_CH-1:0]   start_q;
  logic [N_CH-1:0]   start_edge;
  logic [N_CH-1:0]   len_ok;
  logic [N_CH-1:0]   active_hit;
  logic [N_CH-1:0]   req;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_found;
  logic [15:0]       wdog;

  assign o_state = state;
  assign o_busy  = (state != S_IDLE);

  // Per-channel request qualification
  always_comb begin
    start_edge = ch_start & ~start_q;
    len_ok     = '0;
    active_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      len_ok[i]     = (ch_len[i*LEN_W +: LEN_W] != '0) &&
                      ({1'b0, ch_len[i*LEN_W +: LEN_W]} <= MAX_LEN_L);
      // The channel currently owning the metadata/transfer cannot accept another start
      active_hit[i] = (state != S_IDLE) && (int'(o_meta_ch) == i);
    end
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    int c;
    c           = 0;
    req         = ch_pending & ch_enable;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      c = (int'(last_grant) + k) % N_CH;
      if (!grant_found && req[c]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(c);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      start_q         <= '0;
      last_grant      <= CH_W'(N_CH - 1);
      wdog            <= '0;
      o_meta_valid    <= 1'b0;
      o_meta_len      <= '0;
      o_meta_src_ip   <= '0;
      o_meta_dst_ip   <= '0;
      o_meta_src_port <= '0;
      o_meta_dst_port <= '0;
      o_meta_ch       <= '0;
      ch_pending      <= '0;
      ch_err_len      <= '0;
      ch_err_ovf      <= '0;
      o_timeout       <= 1'b0;
      ch_pkt_cnt      <= '0;
    end else begin
      start_q <= ch_start;

      for (int i = 0; i < N_CH; i++) begin
        if (!ch_enable[i]) begin
          ch_pending[i] <= 1'b0;
        end else if (start_edge[i]) begin
          if (!len_ok[i]) begin
            ch_err_len[i] <= 1'b1;
          end else if (ch_pending[i] || active_hit[i]) begin
            ch_err_ovf[i] <= 1'b1;
          end else begin
            ch_pending[i] <= 1'b1;
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (grant_found) begin
            o_meta_len      <= ch_len[int'(grant_idx)*LEN_W +: LEN_W];
            o_meta_dst_ip   <= ch_dst_ip[int'(grant_idx)*32 +: 32];
            o_meta_dst_port <= ch_dst_port[int'(grant_idx)*16 +: 16];
            o_meta_src_ip   <= SRC_IP;
            o_meta_src_port <= SRC_PORT;
            o_meta_ch       <= grant_idx;
            o_meta_valid    <= 1'b1;
            // A granted channel had pending=1, so the request loop above cannot re-set it
            ch_pending[grant_idx] <= 1'b0;
            last_grant      <= grant_idx;
            state           <= S_META;
          end
        end
        S_META: begin
          if (i_meta_ready) begin
            o_meta_valid <= 1'b0;
            wdog         <= '0;
            state        <= S_XFER;
          end
        end
        S_XFER: begin
          if (mon_tvalid && mon_tready && mon_tlast) begin
            ch_pkt_cnt[int'(o_meta_ch)*32 +: 32] <= ch_pkt_cnt[int'(o_meta_ch)*32 +: 32] + 32'd1;
            state <= S_IDLE;
          end else if (wdog == WD_LAST) begin
            o_timeout <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Last assignment wins: a clear beats any same-cycle increment or flag set
      if (clr_stat) begin
        ch_pkt_cnt <= '0;
        ch_err_len <= '0;
        ch_err_ovf <= '0;
        o_timeout  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rdma_meta_arbiter_ctrl.sv
// tb/tb_rdma_meta_arbiter_ctrl.sv - randomized and directed bench for rdma_meta_arbiter_ctrl
module tb_rdma_meta_arbiter_ctrl;
  localparam int N    = 4;
  localparam int LW   = 16;
  localparam int MAXL = 1472;
  localparam int TO   = 16;
  localparam int ST_IDLE = 0, ST_META = 1, ST_XFER = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    ch_enable = '0, ch_start = '0;
  logic [N*LW-1:0] ch_len = '0;
  logic [N*32-1:0] ch_dst_ip = '0;
  logic [N*16-1:0] ch_dst_port = '0;
  logic clr_stat = 0, i_meta_ready = 0, mon_tvalid = 0, mon_tready = 0, mon_tlast = 0;
  logic [LW-1:0] o_meta_len;
  logic [31:0] o_meta_src_ip, o_meta_dst_ip;
  logic [15:0] o_meta_src_port, o_meta_dst_port;
  logic [1:0] o_meta_ch;
  logic o_meta_valid, o_timeout, o_busy;
  logic [N-1:0] ch_pending, ch_err_len, ch_err_ovf;
  logic [1:0] o_state;
  logic [N*32-1:0] ch_pkt_cnt;

  always #5 clk = ~clk;

  rdma_meta_arbiter_ctrl #(.N_CH(N), .LEN_W(LW), .MAX_LEN(MAXL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ch_enable(ch_enable), .ch_start(ch_start), .ch_len(ch_len),
    .ch_dst_ip(ch_dst_ip), .ch_dst_port(ch_dst_port), .clr_stat(clr_stat),
    .o_meta_len(o_meta_len), .o_meta_src_ip(o_meta_src_ip), .o_meta_dst_ip(o_meta_dst_ip),
    .o_meta_src_port(o_meta_src_port), .o_meta_dst_port(o_meta_dst_port), .o_meta_ch(o_meta_ch),
    .o_meta_valid(o_meta_valid), .i_meta_ready(i_meta_ready), .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready), .mon_tlast(mon_tlast), .ch_pending(ch_pending),
    .ch_err_len(ch_err_len), .ch_err_ovf(ch_err_ovf), .o_timeout(o_timeout), .o_busy(o_busy),
    .o_state(o_state), .ch_pkt_cnt(ch_pkt_cnt));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: transaction-level view of the arbiter
  int          m_phase, m_last, m_ch, m_xfer_clks;
  bit          m_valid, m_to, m_src;
  bit [N-1:0]  m_pend, m_errl, m_ovf, m_prev;
  int unsigned m_cnt[N];
  logic [LW-1:0] m_len;
  logic [31:0]   m_dip;
  logic [15:0]   m_dport;

  task automatic model_reset();
    m_phase = ST_IDLE; m_last = N - 1; m_ch = 0; m_xfer_clks = 0;
    m_valid = 0; m_to = 0; m_src = 0;
    m_pend = '0; m_errl = '0; m_ovf = '0; m_prev = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_len = '0; m_dip = '0; m_dport = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    bit [N-1:0] rise, old_pend;
    int old_phase, old_ch, len, c;
    bit found;
    rise = ch_start & ~m_prev;
    m_prev = ch_start;
    old_pend = m_pend; old_phase = m_phase; old_ch = m_ch;
    for (int i = 0; i < N; i++) begin
      len = int'(ch_len[i*LW +: LW]);
      if (!ch_enable[i]) m_pend[i] = 0;
      else if (rise[i]) begin
        if (len == 0 || len > MAXL) m_errl[i] = 1;
        else if (old_pend[i] || (old_phase != ST_IDLE && old_ch == i)) m_ovf[i] = 1;
        else m_pend[i] = 1;
      end
    end
    if (old_phase == ST_IDLE) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && old_pend[c] && ch_enable[c]) begin
          found = 1;
          m_ch = c; m_last = c; m_pend[c] = 0; m_valid = 1; m_src = 1;
          m_len = ch_len[c*LW +: LW]; m_dip = ch_dst_ip[c*32 +: 32]; m_dport = ch_dst_port[c*16 +: 16];
          m_phase = ST_META;
        end
      end
    end else if (old_phase == ST_META) begin
      if (i_meta_ready) begin
        m_valid = 0; m_phase = ST_XFER; m_xfer_clks = 0;
      end
    end else begin
      m_xfer_clks++;
      if (mon_tvalid && mon_tready && mon_tlast) begin
        m_cnt[m_ch]++; m_phase = ST_IDLE;
      end else if (m_xfer_clks == TO) begin
        m_to = 1; m_phase = ST_IDLE;
      end
    end
    if (clr_stat) begin
      m_errl = '0; m_ovf = '0; m_to = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end
  endtask

  task automatic check_all();
    chk("state", o_state, m_phase);
    chk("valid", o_meta_valid, m_valid);
    chk("busy", o_busy, m_phase != ST_IDLE);
    chk("pending", ch_pending, m_pend);
    chk("err_len", ch_err_len, m_errl);
    chk("err_ovf", ch_err_ovf, m_ovf);
    chk("timeout", o_timeout, m_to);
    chk("meta_ch", o_meta_ch, m_ch);
    chk("meta_len", o_meta_len, m_len);
    chk("meta_dip", o_meta_dst_ip, m_dip);
    chk("meta_dport", o_meta_dst_port, m_dport);
    chk("meta_sip", o_meta_src_ip, m_src ? 32'hAC1F09CA : 32'h0);
    chk("meta_sport", o_meta_src_port, m_src ? 16'hCE06 : 16'h0);
    for (int i = 0; i < N; i++) chk($sformatf("cnt%0d", i), ch_pkt_cnt[i*32 +: 32], m_cnt[i]);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_start = '0; clr_stat = 0; i_meta_ready = 0;
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    ch_enable = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
  endtask

  int q_order[$];
  int since;
  bit in_x, seen_valid;

  initial begin
    // Reset state
    do_reset();

    // Single transfer on channel 0 with latency and field checks
    ch_len[0 +: LW] = 16'd64; ch_dst_ip[0 +: 32] = 32'hC0A80A02; ch_dst_port[0 +: 16] = 16'h12B7;
    ch_start[0] = 1;
    cycle();
    chk("lat_edge1_valid", o_meta_valid, 1'b0);
    cycle();
    chk("lat_edge2_valid", o_meta_valid, 1'b1);
    chk("t1_len", o_meta_len, 16'd64);
    chk("t1_dip", o_meta_dst_ip, 32'hC0A80A02);
    chk("t1_dport", o_meta_dst_port, 16'h12B7);
    i_meta_ready = 1; ch_start[0] = 0;
    cycle();
    i_meta_ready = 0; mon_tvalid = 1; mon_tready = 1; mon_tlast = 1;
    cycle();
    chk("t1_cnt0", ch_pkt_cnt[31:0], 32'd1);
    chk("t1_idle", o_state, 2'd0);
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    cycle();

    // Four simultaneous starts, ready and tlast held high
    do_reset();
    for (int i = 0; i < N; i++) begin
      ch_len[i*LW +: LW] = 16'(100 + i); ch_dst_ip[i*32 +: 32] = 32'h0A000000 + i;
      ch_dst_port[i*16 +: 16] = 16'(1000 + i);
    end
    ch_start = '1; i_meta_ready = 1; mon_tvalid = 1; mon_tready = 1; mon_tlast = 1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (o_meta_valid) q_order.push_back(int'(o_meta_ch));
    end
    chk("rr_grants", q_order.size(), 4);
    for (int j = 0; j < 4; j++) chk($sformatf("rr_order%0d", j), (j < q_order.size()) ? q_order[j] : 99, j);
    for (int i = 0; i < N; i++) chk($sformatf("rr_cnt%0d", i), ch_pkt_cnt[i*32 +: 32], 1);

    // Illegal lengths on channel 1
    do_reset();
    seen_valid = 0;
    ch_len[LW +: LW] = 16'd0; ch_start[1] = 1;
    cycle(); seen_valid |= o_meta_valid;
    ch_start[1] = 0;
    cycle(); seen_valid |= o_meta_valid;
    ch_len[LW +: LW] = 16'd1500; ch_start[1] = 1;
    for (int k = 0; k < 5; k++) begin cycle(); seen_valid |= o_meta_valid; end
    chk("len_err1", ch_err_len[1], 1'b1);
    chk("len_no_valid", seen_valid, 1'b0);

    // Watchdog expiry on channel 2
    do_reset();
    ch_len[2*LW +: LW] = 16'd100; ch_start[2] = 1; i_meta_ready = 1;
    in_x = 0; since = 0;
    for (int k = 0; k < 40 && !o_timeout; k++) begin
      cycle();
      if (in_x) since++;
      else if (o_state == 2'd2) begin in_x = 1; since = 0; end
    end
    chk("to_flag", o_timeout, 1'b1);
    chk("to_clocks", since, TO);
    chk("to_idle", o_state, 2'd0);
    chk("to_cnt2", ch_pkt_cnt[2*32 +: 32], 32'd0);

    // Overflow on active channel, then reset during META
    do_reset();
    ch_len[3*LW +: LW] = 16'd200; ch_start[3] = 1; i_meta_ready = 1;
    repeat (3) cycle();
    ch_start[3] = 0; cycle();
    ch_start[3] = 1; cycle();
    chk("ovf3", ch_err_ovf[3], 1'b1);
    mon_tvalid = 1; mon_tready = 1; mon_tlast = 1; cycle();
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0; i_meta_ready = 0;
    ch_len[0 +: LW] = 16'd50; ch_start[0] = 1;
    cycle(); cycle();
    chk("pre_rst_valid", o_meta_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", o_meta_valid, 1'b0);
    chk("rst_state", o_state, 2'd0);
    chk("rst_ovf", ch_err_ovf, 4'h0);
    chk("rst_cnt", ch_pkt_cnt, '0);
    chk("rst_len", o_meta_len, 16'd0);
    chk("rst_pend", ch_pending, 4'h0);
    do_reset();

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) ch_start[i] = ~ch_start[i];
        ch_enable[i] = ($urandom_range(9) != 0);
        case ($urandom_range(5))
          0: ch_len[i*LW +: LW] = 16'd0;
          1: ch_len[i*LW +: LW] = 16'(MAXL);
          2: ch_len[i*LW +: LW] = 16'(MAXL + 1);
          default: ch_len[i*LW +: LW] = 16'($urandom_range(1, 1600));
        endcase
        ch_dst_ip[i*32 +: 32] = $urandom;
        ch_dst_port[i*16 +: 16] = 16'($urandom);
      end
      i_meta_ready = $urandom_range(1);
      mon_tvalid = $urandom_range(1); mon_tready = $urandom_range(1);
      mon_tlast = ($urandom_range(3) == 0);
      clr_stat = ($urandom_range(60) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rdma_meta_arbiter_ctrl.md
RDMA_META_ARBITER_CTRL -- requirements
Module: rdma_meta_arbiter_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4, giving the number of request channels (range 1..8).
REQ-002 SHALL have parameter LEN_W, default 16, giving the payload length width in bits.
REQ-003 SHALL have parameter MAX_LEN, default 1472, giving the largest legal payload length in bytes.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 65535, giving the transfer watchdog limit in clocks (range 2..65535).
REQ-005 SHALL have parameters SRC_IP = 32'hAC1F09CA and SRC_PORT = 16'hCE06, giving the fixed source address and port.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; every flop updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port ch_enable, input, N_CH bits: per-channel enable.
REQ-009 SHALL have port ch_start, input, N_CH bits: per-channel start level; only its rising edge is acted on.
REQ-010 SHALL have port ch_len, input, N_CH*LEN_W bits: packed per-channel payload lengths; channel i uses bits [i*LEN_W +: LEN_W].
REQ-011 SHALL have ports ch_dst_ip (input, N_CH*32) and ch_dst_port (input, N_CH*16): packed per-channel destination IP and port.
REQ-012 SHALL have port clr_stat, input, 1 bit: synchronous clear of counters and sticky flags.
REQ-013 SHALL have outputs o_meta_len (LEN_W), o_meta_src_ip (32), o_meta_dst_ip (32), o_meta_src_port (16), o_meta_dst_port (16) and o_meta_ch ($clog2(N_CH), minimum 1): the metadata sent to the encapsulator.
REQ-014 SHALL have output o_meta_valid and input i_meta_ready, 1 bit each: the metadata handshake.
REQ-015 SHALL have inputs mon_tvalid, mon_tready and mon_tlast, 1 bit each: a monitor tap on the packet output stream.
REQ-016 SHALL have outputs ch_pending (N_CH), ch_err_len (N_CH, sticky), ch_err_ovf (N_CH, sticky), o_timeout (1, sticky), o_busy (1) and o_state (2).
REQ-017 SHALL have output ch_pkt_cnt, N_CH*32 bits: packed per-channel completed-packet counters.

Function
REQ-018 SHALL detect a start edge on channel i as ch_start[i]=1 while its registered copy from the previous clock is 0.
REQ-019 On a start edge with ch_enable[i]=1 and 1<=len<=MAX_LEN: SHALL set ch_pending[i] on that clock edge.
REQ-020 On a start edge with length 0 or length >MAX_LEN: SHALL set ch_err_len[i], leave ch_pending[i] unchanged and issue nothing.
REQ-021 On a start edge while ch_pending[i]=1, or while channel i is the active channel in META/XFER: SHALL set ch_err_ovf[i] and drop the request.
REQ-022 While ch_enable[i]=0: SHALL clear ch_pending[i]; a start edge with enable low SHALL be ignored and set no flag.
REQ-023 SHALL implement state machine IDLE=0, META=1, XFER=2 and output it on o_state.
REQ-024 IDLE: if any ch_pending bit is set, SHALL grant one channel by round-robin, searching from (last grant+1) modulo N_CH upward.
REQ-025 On a grant, in the same edge: SHALL latch all o_meta_* fields from the granted channel, clear its pending bit, set o_meta_valid=1, update the last-grant pointer and move to META.
REQ-026 After reset the last-grant pointer SHALL be N_CH-1, so channel 0 has first priority.
REQ-027 META: o_meta_valid and all o_meta_* fields SHALL stay stable until i_meta_ready=1; on the ready clock o_meta_valid SHALL drop to 0 and the state SHALL move to XFER.
REQ-028 XFER: on mon_tvalid&mon_tready&mon_tlast, SHALL increment ch_pkt_cnt of the active channel and return to IDLE.
REQ-029 XFER: the watchdog SHALL count clocks from XFER entry; on reaching TIMEOUT_CYC it SHALL set o_timeout and return to IDLE without incrementing any counter.
REQ-030 A tlast beat seen in IDLE or META SHALL be ignored.
REQ-031 Packet counters SHALL wrap from 32'hFFFFFFFF to 0 with no flag.
REQ-032 o_busy SHALL be 1 in META and XFER, and 0 in IDLE.
REQ-033 Latency: with the machine idle, o_meta_valid SHALL rise on the 2nd rising edge after the clock in which the start edge is sampled.
REQ-034 clr_stat SHALL zero all counters, ch_err_len, ch_err_ovf and o_timeout; if it coincides with an increment or a flag set, the clear SHALL win.
REQ-035 Simultaneous start edges on several channels SHALL all set pending and be served one per transaction in round-robin order.

Reset
REQ-036 While rst=1 (asynchronously), SHALL force: state IDLE, o_meta_valid=0, all o_meta_* =0, all pending bits, error flags and counters =0, start-edge registers =0, watchdog =0, last-grant pointer =N_CH-1.
REQ-037 Reset asserted mid-META or mid-XFER SHALL abandon the transaction; o_meta_valid SHALL be 0 the moment rst rises.

Verification
REQ-038 Channel 0: len=64, dst_ip=C0A80A02, port=0x12B7; start rise; ready one clock after valid; one tlast beat -> o_meta_valid high 2 clocks after start, fields match, ch_pkt_cnt[0]=1, back in IDLE.
REQ-039 Start edges on channels 0..3 in the same clock; ready tied high -> grant order 0,1,2,3; four packets later every counter =1.
REQ-040 Channel 1: len=0, then len=1500 -> ch_err_len[1]=1 and o_meta_valid never asserts.
REQ-041 TIMEOUT_CYC=16; grant with no tlast -> o_timeout=1 at the 16th XFER clock, state IDLE, counter unchanged.
REQ-042 Second start edge on the active channel during XFER -> ch_err_ovf set; rst pulse mid-META -> o_meta_valid=0 immediately and all outputs at their reset values.
